reg_bank_dump: RTL and testbench

MIPS general-purpose register file, 32 x 32-bit, sitting directly downstream of mux_regDst. Its write-register address comes from mux_wr_reg_out; it supplies the registered A/B operands to the multicycle datapath. It also has a sequential debug-dump port that streams all 32 registers out, one per cycle, under a start/busy/valid/done handshake.

---
 rtl/reg_bank_dump_if.sv | 36 +++
 rtl/reg_bank_dump.sv | 123 ++++++++++++
 tb/tb_reg_bank_dump.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_dump_if
// Brief    : Read/write and debug-dump signal bundle for the register bank.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_bank_dump_if #(
  parameter int DATA_W = 32
);
  logic              reg_write;
  logic [4:0]        read_reg1;
  logic [4:0]        read_reg2;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic [4:0]        dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;

  modport master (
    output reg_write, read_reg1, read_reg2, write_reg, write_data, dump_start,
    input  read_data1, read_data2, dump_busy, dump_valid, dump_idx, dump_data,
           dump_done
  );

  modport slave (
    input  reg_write, read_reg1, read_reg2, write_reg, write_data, dump_start,
    output read_data1, read_data2, dump_busy, dump_valid, dump_idx, dump_data,
           dump_done
  );
endinterface
`default_nettype wire

// File: rtl/reg_bank_dump.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_dump
// Brief    : 32x32 MIPS register file, registered reads with write bypass,
//            plus a sequential debug dump of all registers.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_dump #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(227)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  reg_bank_dump_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_regs [32];
  state_t            r_state;
  logic [4:0]        r_cnt;
  logic [DATA_W-1:0] r_read_data1;
  logic [DATA_W-1:0] r_read_data2;
  logic              r_busy;
  logic              r_valid;
  logic [4:0]        r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_done;

  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_dump_rd;

  assign w_wr_en = bus.reg_write && (bus.write_reg != 5'd0);

  // Every read path sees this cycle's write, so readers never observe stale data.
  always_comb begin
    w_rd1     = r_regs[bus.read_reg1];
    w_rd2     = r_regs[bus.read_reg2];
    w_dump_rd = r_regs[r_cnt];
    if (w_wr_en && (bus.write_reg == bus.read_reg1)) w_rd1     = bus.write_data;
    if (w_wr_en && (bus.write_reg == bus.read_reg2)) w_rd2     = bus.write_data;
    if (w_wr_en && (bus.write_reg == r_cnt))         w_dump_rd = bus.write_data;
    if (bus.read_reg1 == 5'd0) w_rd1     = '0;
    if (bus.read_reg2 == 5'd0) w_rd2     = '0;
    if (r_cnt == 5'd0)         w_dump_rd = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == 29) ? SP_INIT : '0;
      end
    end else if (w_wr_en) begin
      r_regs[bus.write_reg] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_data1 <= '0;
      r_read_data2 <= '0;
    end else begin
      r_read_data1 <= w_rd1;
      r_read_data2 <= w_rd2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= 5'd0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_valid <= 1'b0;
          if (bus.dump_start) begin
            r_state <= ST_DUMP;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_DUMP: begin
          r_valid <= 1'b1;
          r_idx   <= r_cnt;
          r_data  <= w_dump_rd;
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= ST_DONE;
        end
        ST_DONE: begin
          // Busy stays high through the done pulse and drops one edge later.
          r_valid <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.read_data1 = r_read_data1;
  assign bus.read_data2 = r_read_data2;
  assign bus.dump_busy  = r_busy;
  assign bus.dump_valid = r_valid;
  assign bus.dump_idx   = r_idx;
  assign bus.dump_data  = r_data;
  assign bus.dump_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_dump
// Brief    : Self-checking bench for reg_bank_dump against a register-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_dump;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  reg_bank_dump_if #(.DATA_W(32)) bif ();

  reg_bank_dump #(
    .DATA_W  (32),
    .SP_INIT (32'd227)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: register contents as they stand at the end of each cycle.
  logic [31:0] m [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = (i == 29) ? 32'd227 : 32'd0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock edge; the model takes the write seen at that edge.
  task automatic cycle();
    @(posedge clk);
    if (bif.reg_write && bif.write_reg != 5'd0) m[bif.write_reg] = bif.write_data;
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bif.reg_write  = we;
    bif.write_reg  = wa;
    bif.write_data = wd;
    bif.read_reg1  = ra1;
    bif.read_reg2  = ra2;
  endtask

  // mode 0: quiet; 1: late write to reg 31 + mid-dump start; 2: random traffic.
  task automatic run_dump(input int mode);
    bif.dump_start = 1'b1;
    cycle();
    bif.dump_start = 1'b0;
    chk("start_busy", {31'd0, bif.dump_busy}, 32'd1);
    chk("start_valid", {31'd0, bif.dump_valid}, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      if (mode == 1 && k == 10) bif.dump_start = 1'b1;
      if (mode == 1 && k == 32) drive(1'b1, 5'd31, 32'h0000_0040, 5'd0, 5'd0);
      if (mode == 2)
        drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle();
      chk("dump_valid", {31'd0, bif.dump_valid}, 32'd1);
      chk("dump_busy", {31'd0, bif.dump_busy}, 32'd1);
      chk("dump_idx", {27'd0, bif.dump_idx}, k - 1);
      chk("dump_data", bif.dump_data, mread(5'(k - 1)));
      chk("dump_done_early", {31'd0, bif.dump_done}, 32'd0);
      if (mode == 2) begin
        chk("dump_rd1", bif.read_data1, mread(bif.read_reg1));
        chk("dump_rd2", bif.read_data2, mread(bif.read_reg2));
      end
      bif.dump_start = 1'b0;
      bif.reg_write  = 1'b0;
    end
    cycle();
    chk("done_pulse", {31'd0, bif.dump_done}, 32'd1);
    chk("done_valid", {31'd0, bif.dump_valid}, 32'd0);
    chk("done_busy", {31'd0, bif.dump_busy}, 32'd1);
    chk("done_idx_hold", {27'd0, bif.dump_idx}, 32'd31);
    cycle();
    chk("post_done", {31'd0, bif.dump_done}, 32'd0);
    chk("post_busy", {31'd0, bif.dump_busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd0,  5'd0,  32'd0,          32'd0};
    vecs[1] = '{1'b0, 5'd0,  32'd0,         5'd8,  5'd8,  32'hDEAD_BEEF,  32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd8,  32'h1234_5678, 5'd8,  5'd0,  32'h1234_5678,  32'd0};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'd0,          32'd0};
    vecs[4] = '{1'b0, 5'd0,  32'd0,         5'd0,  5'd8,  32'd0,          32'h1234_5678};
    vecs[5] = '{1'b0, 5'd29, 32'h0000_0100, 5'd29, 5'd29, 32'd227,        32'd227};
    vecs[6] = '{1'b1, 5'd5,  32'h0000_A5A5, 5'd29, 5'd5,  32'd227,        32'h0000_A5A5};
    vecs[7] = '{1'b0, 5'd0,  32'd0,         5'd5,  5'd31, 32'h0000_A5A5,  32'd0};
    vecs[8] = '{1'b1, 5'd31, 32'h0BAD_F00D, 5'd31, 5'd8,  32'h0BAD_F00D,  32'h1234_5678};

    reset = 1'b0;
    bif.dump_start = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    model_reset();
    #23;
    chk("rst_rd1", bif.read_data1, 32'd0);
    chk("rst_rd2", bif.read_data2, 32'd0);
    chk("rst_busy", {31'd0, bif.dump_busy}, 32'd0);
    chk("rst_valid", {31'd0, bif.dump_valid}, 32'd0);
    chk("rst_done", {31'd0, bif.dump_done}, 32'd0);
    chk("rst_data", bif.dump_data, 32'd0);
    reset = 1'b1;
    cycle();

    run_dump(0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      cycle();
      chk($sformatf("vec%0d_rd1", i), bif.read_data1, vecs[i].e1);
      chk($sformatf("vec%0d_rd2", i), bif.read_data2, vecs[i].e2);
    end
    bif.reg_write = 1'b0;

    run_dump(0);
    run_dump(1);

    for (int n = 0; n < 200; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (n % 16 == 0) bif.read_reg2 = bif.write_reg;
      cycle();
      chk("rand_rd1", bif.read_data1, mread(bif.read_reg1));
      chk("rand_rd2", bif.read_data2, mread(bif.read_reg2));
    end
    bif.reg_write = 1'b0;
    run_dump(2);

    // Abort a dump part-way with an asynchronous reset.
    drive(1'b1, 5'd8, 32'hCAFE_0008, 5'd0, 5'd0);
    cycle();
    bif.reg_write  = 1'b0;
    bif.dump_start = 1'b1;
    cycle();
    bif.dump_start = 1'b0;
    for (int k = 1; k <= 16; k++) cycle();
    chk("pre_abort_idx", {27'd0, bif.dump_idx}, 32'd15);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", {31'd0, bif.dump_busy}, 32'd0);
    chk("abort_valid", {31'd0, bif.dump_valid}, 32'd0);
    chk("abort_idx", {27'd0, bif.dump_idx}, 32'd0);
    chk("abort_data", bif.dump_data, 32'd0);
    chk("abort_done", {31'd0, bif.dump_done}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("abort_no_done", {31'd0, bif.dump_done}, 32'd0);
      chk("abort_no_busy", {31'd0, bif.dump_busy}, 32'd0);
    end
    drive(1'b0, 5'd29, 32'h0000_0100, 5'd29, 5'd8);
    cycle();
    chk("abort_sp", bif.read_data1, 32'd227);
    chk("abort_r8", bif.read_data2, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    cycle();
    chk("abort_r5", bif.read_data1, 32'd0);
    chk("abort_r31", bif.read_data2, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
